fifo_rr_scheduler: RTL and testbench

- Round-robin read scheduler that drains NCH first-word-fall-through channel FIFOs onto one shared output stream.
- Grants one channel at a time for up to BURST beats. Pops that channel's FIFO via its rinc and registers each word into an output stage with a valid/ready handshake.
- Sits between the per-channel ingress FIFOs and the single downstream consumer, for example a DMA write port.

---
 rtl/fifo_sched_pkg.sv | 38 +++
 rtl/rr_pick_nch.sv | 23 ++
 rtl/fifo_rr_scheduler.sv | 99 +++++++++
 tb/tb_fifo_rr_scheduler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types and the round-robin search used by the channel FIFO schedulers.
// rr_pick works on a MAX_NCH-wide request vector so one function serves any channel count.
package fifo_sched_pkg;

    localparam int NCH_DFLT = 4;
    localparam int CHW      = $clog2(NCH_DFLT);
    localparam int MAX_NCH  = 64;
    localparam int MAX_CHW  = $clog2(MAX_NCH);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    // First requester after 'last' (mod n); 'last' itself is checked last.
    function automatic logic rr_pick(
        input  logic [MAX_NCH-1:0] req,
        input  int                 last,
        input  int                 n,
        output int                 sel
    );
        logic found;
        found = 1'b0;
        sel   = 0;
        for (int k = MAX_NCH; k >= 1; k--) begin
            if (k <= n) begin
                int idx;
                idx = (last + k) % n;
                if (req[MAX_CHW'(idx)]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/rr_pick_nch.sv
// Combinational round-robin priority finder: lowest priority goes to 'last'.
// Zero latency; no handshake.
module rr_pick_nch
    import fifo_sched_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]          req,
    input  logic [$clog2(NCH)-1:0]  last,
    output logic [$clog2(NCH)-1:0]  sel,
    output logic                    found
);

    localparam int SW = $clog2(NCH);

    always_comb begin
        int sel_i;
        sel_i = 0;
        found = rr_pick(MAX_NCH'(req), int'(last), NCH, sel_i);
        sel   = SW'(sel_i);
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of NCH FWFT channel FIFOs onto one stream, up to BURST beats per grant.
// Data appears two cycles after a channel turns non-empty; out_ready low freezes the output and stops pops.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 512,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     en,
    input  logic [NCH-1:0]           ch_rempty,
    input  logic [NCH*WIDTH-1:0]     ch_rdata,
    output logic [NCH-1:0]           ch_rinc,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(NCH)-1:0]   out_ch,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int SW  = $clog2(NCH);
    localparam int BCW = $clog2(BURST + 1);

    sched_state_e   state;
    logic [SW-1:0]  gnt;
    logic [SW-1:0]  last;
    logic [BCW-1:0] beat_cnt;
    logic [NCH-1:0] req;
    logic [SW-1:0]  sel;
    logic           found;
    logic           gnt_empty;
    logic           pop;

    assign req       = ~ch_rempty;
    assign gnt_empty = ch_rempty[gnt];
    assign pop       = (state == GRANT) && !gnt_empty && (!out_valid || out_ready);
    assign busy      = (state == GRANT);

    always_comb begin
        ch_rinc      = '0;
        ch_rinc[gnt] = pop;
    end

    rr_pick_nch #(.NCH(NCH)) u_pick (
        .req   (req),
        .last  (last),
        .sel   (sel),
        .found (found)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            gnt      <= '0;
            last     <= SW'(NCH - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && found) begin
                        gnt      <= sel;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // An empty channel forfeits the remainder of its burst.
                    if (gnt_empty) begin
                        state <= IDLE;
                        last  <= gnt;
                    end else if (pop) begin
                        beat_cnt <= beat_cnt + BCW'(1);
                        if (beat_cnt == BCW'(BURST - 1)) begin
                            state <= IDLE;
                            last  <= gnt;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= ch_rdata[gnt*WIDTH +: WIDTH];
            out_ch    <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: queue-based FWFT channel models, negedge output log.
module tb_fifo_rr_scheduler;

    localparam int NCH   = 4;
    localparam int WIDTH = 16;
    localparam int BURST = 4;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   en;
    logic [NCH-1:0]         ch_rempty;
    logic [NCH*WIDTH-1:0]   ch_rdata;
    logic [NCH-1:0]         ch_rinc;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [1:0]             out_ch;
    logic                   out_ready;
    logic                   busy;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;
    int underflows = 0;

    logic [WIDTH-1:0] fq[NCH][$];
    int               lg_cyc[$];
    int               lg_ch[$];
    logic [WIDTH-1:0] lg_dat[$];
    logic [NCH-1:0]   rinc_s = '0;

    fifo_rr_scheduler #(.NCH(NCH), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .ch_rempty (ch_rempty),
        .ch_rdata  (ch_rdata),
        .ch_rinc   (ch_rinc),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic refresh();
        for (int i = 0; i < NCH; i++) begin
            ch_rempty[i] = (fq[i].size() == 0);
            ch_rdata[i*WIDTH +: WIDTH] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    always @(negedge clk) begin
        rinc_s = ch_rinc;
        if (resetn && out_valid && out_ready) begin
            lg_cyc.push_back(cyc);
            lg_ch.push_back(int'(out_ch));
            lg_dat.push_back(out_data);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (rinc_s[i]) begin
                if (fq[i].size() == 0) underflows++;
                else fq[i].delete(0);
            end
        end
        refresh();
    end

    task automatic clear_log();
        lg_cyc.delete();
        lg_ch.delete();
        lg_dat.delete();
    endtask

    task automatic reset_dut();
        @(posedge clk); #2;
        resetn = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) fq[i].delete();
        refresh();
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        clear_log();
    endtask

    function automatic logic all_empty();
        for (int i = 0; i < NCH; i++) if (fq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input int max);
        int n = 0;
        while (!(all_empty() && !busy && !out_valid) && n < max) begin
            @(posedge clk); #2;
            n++;
        end
        asserts++;
        if (n >= max) begin
            fails++;
            $display("FAIL drain_timeout: waited %0d cycles, required idle within %0d", n, max);
        end
    endtask

    task automatic wait_word(input logic [WIDTH-1:0] w, input int max, output logic ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < max) begin
            @(posedge clk); #2;
            if (out_valid && out_data == w) ok = 1'b1;
            n++;
        end
        asserts++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_word: word %h never shown within %0d cycles", w, max);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        asserts++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ch_rinc !== '0 || out_data !== '0 || out_ch !== 2'd0) begin
            fails++;
            $display("FAIL reset_values: valid=%b busy=%b rinc=%b data=%h ch=%0d, required all zero",
                     out_valid, busy, ch_rinc, out_data, out_ch);
        end
        reset_dut();
    endtask

    task automatic test_single_channel();
        int c_push;
        int exp_off;
        reset_dut();
        @(posedge clk); #2;
        for (int i = 0; i < 6; i++) fq[1].push_back(WIDTH'(16'h00A0 + i));
        refresh();
        c_push = cyc;
        wait_drain(100);
        asserts++;
        if (lg_dat.size() !== 6) begin
            fails++;
            $display("FAIL single_count: got %0d beats, required 6", lg_dat.size());
        end
        if (lg_dat.size() > 0) begin
            asserts++;
            if (lg_cyc[0] !== c_push + 2) begin
                fails++;
                $display("FAIL single_latency: first beat at cycle %0d, required %0d", lg_cyc[0], c_push + 2);
            end
        end
        for (int i = 0; i < 6 && i < lg_dat.size(); i++) begin
            exp_off = (i < 4) ? i : i + 1;
            asserts++;
            if (lg_dat[i] !== WIDTH'(16'h00A0 + i) || lg_ch[i] !== 1 || lg_cyc[i] - lg_cyc[0] !== exp_off) begin
                fails++;
                $display("FAIL single_beat%0d: data=%h ch=%0d off=%0d, required data=%h ch=1 off=%0d",
                         i, lg_dat[i], lg_ch[i], lg_cyc[i] - lg_cyc[0], 16'h00A0 + i, exp_off);
            end
        end
        asserts++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL single_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_fairness();
        int ec, ew;
        reset_dut();
        @(posedge clk); #2;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 8; i++) fq[c].push_back(WIDTH'(16'h1000 + c * 256 + i));
        refresh();
        wait_drain(300);
        asserts++;
        if (lg_dat.size() !== 32) begin
            fails++;
            $display("FAIL fair_count: got %0d beats, required 32", lg_dat.size());
        end
        for (int n = 0; n < 32 && n < lg_dat.size(); n++) begin
            ec = (n / 4) % 4;
            ew = 16'h1000 + ec * 256 + (n / 16) * 4 + (n % 4);
            asserts++;
            if (lg_ch[n] !== ec || lg_dat[n] !== WIDTH'(ew) || lg_cyc[n] - lg_cyc[0] !== n + n / 4) begin
                fails++;
                $display("FAIL fair_beat%0d: ch=%0d data=%h off=%0d, required ch=%0d data=%h off=%0d",
                         n, lg_ch[n], lg_dat[n], lg_cyc[n] - lg_cyc[0], ec, ew, n + n / 4);
            end
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        reset_dut();
        @(posedge clk); #2;
        for (int i = 0; i < 8; i++) fq[2].push_back(WIDTH'(16'h2200 + i));
        refresh();
        wait_word(16'h2201, 20, ok);
        out_ready = 1'b0;
        #1;
        asserts++;
        if (ch_rinc !== '0) begin
            fails++;
            $display("FAIL bp_rinc_drop: rinc=%b, required 0000", ch_rinc);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            asserts++;
            if (ch_rinc !== '0 || out_valid !== 1'b1 || out_data !== 16'h2201 || out_ch !== 2'd2) begin
                fails++;
                $display("FAIL bp_stall%0d: rinc=%b valid=%b data=%h ch=%0d, required 0000 1 2201 2",
                         k, ch_rinc, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        wait_drain(100);
        asserts++;
        if (lg_dat.size() !== 8) begin
            fails++;
            $display("FAIL bp_count: got %0d beats, required 8", lg_dat.size());
        end
        for (int i = 0; i < 8 && i < lg_dat.size(); i++) begin
            asserts++;
            if (lg_dat[i] !== WIDTH'(16'h2200 + i) || lg_ch[i] !== 2) begin
                fails++;
                $display("FAIL bp_beat%0d: data=%h ch=%0d, required data=%h ch=2",
                         i, lg_dat[i], lg_ch[i], 16'h2200 + i);
            end
        end
    endtask

    task automatic test_early_empty();
        logic [WIDTH-1:0] ed[6];
        int               ech[6];
        reset_dut();
        @(posedge clk); #2;
        fq[2].push_back(16'h3200);
        refresh();
        wait_drain(50);
        clear_log();
        fq[3].push_back(16'h3300);
        fq[3].push_back(16'h3301);
        for (int i = 0; i < 4; i++) fq[0].push_back(WIDTH'(16'h3000 + i));
        refresh();
        wait_drain(100);
        ed  = '{16'h3300, 16'h3301, 16'h3000, 16'h3001, 16'h3002, 16'h3003};
        ech = '{3, 3, 0, 0, 0, 0};
        asserts++;
        if (lg_dat.size() !== 6) begin
            fails++;
            $display("FAIL early_count: got %0d beats, required 6", lg_dat.size());
        end
        for (int i = 0; i < 6 && i < lg_dat.size(); i++) begin
            asserts++;
            if (lg_dat[i] !== ed[i] || lg_ch[i] !== ech[i]) begin
                fails++;
                $display("FAIL early_beat%0d: data=%h ch=%0d, required data=%h ch=%0d",
                         i, lg_dat[i], lg_ch[i], ed[i], ech[i]);
            end
        end
        if (lg_dat.size() >= 3) begin
            asserts++;
            if (lg_cyc[2] - lg_cyc[1] !== 3) begin
                fails++;
                $display("FAIL early_gap: gap %0d cycles, required 3", lg_cyc[2] - lg_cyc[1]);
            end
        end
    endtask

    task automatic test_en_gating();
        logic ok;
        logic idle_ok;
        logic [WIDTH-1:0] ew;
        reset_dut();
        @(posedge clk); #2;
        for (int i = 0; i < 8; i++) fq[1].push_back(WIDTH'(16'h4100 + i));
        for (int i = 0; i < 4; i++) fq[2].push_back(WIDTH'(16'h4200 + i));
        refresh();
        wait_word(16'h4101, 20, ok);
        en = 1'b0;
        repeat (4) begin
            @(posedge clk); #2;
        end
        idle_ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #2;
            if (busy !== 1'b0 || ch_rinc !== '0 || out_valid !== 1'b0) idle_ok = 1'b0;
        end
        asserts++;
        if (!idle_ok) begin
            fails++;
            $display("FAIL en_hold: activity seen while en=0 (busy=%b rinc=%b), required none", busy, ch_rinc);
        end
        asserts++;
        if (lg_dat.size() !== 4) begin
            fails++;
            $display("FAIL en_partial: got %0d beats before re-enable, required 4", lg_dat.size());
        end
        en = 1'b1;
        wait_drain(100);
        asserts++;
        if (lg_dat.size() !== 12) begin
            fails++;
            $display("FAIL en_count: got %0d beats, required 12", lg_dat.size());
        end
        for (int n = 0; n < 12 && n < lg_dat.size(); n++) begin
            if (n < 4)      ew = WIDTH'(16'h4100 + n);
            else if (n < 8) ew = WIDTH'(16'h4200 + n - 4);
            else            ew = WIDTH'(16'h4100 + n - 4);
            asserts++;
            if (lg_dat[n] !== ew) begin
                fails++;
                $display("FAIL en_beat%0d: data=%h, required %h", n, lg_dat[n], ew);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic ok;
        logic [WIDTH-1:0] ew;
        int ec;
        reset_dut();
        @(posedge clk); #2;
        for (int i = 0; i < 8; i++) fq[1].push_back(WIDTH'(16'h5100 + i));
        for (int i = 0; i < 4; i++) fq[2].push_back(WIDTH'(16'h5200 + i));
        refresh();
        wait_word(16'h5101, 20, ok);
        resetn = 1'b0;
        #1;
        asserts++;
        if (out_valid !== 1'b0 || ch_rinc !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_async: valid=%b rinc=%b busy=%b, required 0 0000 0", out_valid, ch_rinc, busy);
        end
        clear_log();
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        wait_drain(100);
        asserts++;
        if (lg_dat.size() !== 10) begin
            fails++;
            $display("FAIL rst_mid_count: got %0d beats, required 10", lg_dat.size());
        end
        for (int n = 0; n < 5 && n < lg_dat.size(); n++) begin
            ew = (n < 4) ? WIDTH'(16'h5102 + n) : 16'h5200;
            ec = (n < 4) ? 1 : 2;
            asserts++;
            if (lg_dat[n] !== ew || lg_ch[n] !== ec) begin
                fails++;
                $display("FAIL rst_mid_beat%0d: data=%h ch=%0d, required data=%h ch=%0d",
                         n, lg_dat[n], lg_ch[n], ew, ec);
            end
        end
    endtask

    task automatic test_no_underflow();
        asserts++;
        if (underflows !== 0) begin
            fails++;
            $display("FAIL underflow: %0d pops of empty channels, required 0", underflows);
        end
    endtask

    initial begin
        resetn = 1'b0;
        en = 1'b0;
        out_ready = 1'b0;
        refresh();
        test_reset();
        test_single_channel();
        test_fairness();
        test_backpressure();
        test_early_empty();
        test_en_gating();
        test_reset_mid_burst();
        test_no_underflow();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
